// File: rtl/student_pkg.sv
// Shared definitions for the student day logger: state codes, widths and the
// legal-successor table used by the optional legality check
// (STUDENT_LOG_ILLEGAL_CHECK_EN).
package student_pkg;

    localparam int STATE_W    = 5;
    localparam int NUM_STATES = 11;

    typedef enum logic [STATE_W-1:0] {
        S_SLEEP   = 5'd0,
        S_AWAKE   = 5'd1,
        S_BUS_IN  = 5'd2,
        S_LECTURE = 5'd3,
        S_STUDY   = 5'd4,
        S_DESIGN  = 5'd5,
        S_DINNER  = 5'd6,
        S_BUS_OUT = 5'd7,
        S_GYM     = 5'd8,
        S_TV      = 5'd9,
        S_COFFEE  = 5'd10
    } student_state_t;

    // Successor set of each state as a one-hot mask indexed by the target code.
    //   SLEEP   -> AWAKE
    //   AWAKE   -> BUS_IN, COFFEE
    //   BUS_IN  -> LECTURE
    //   LECTURE -> STUDY, DESIGN, BUS_OUT, COFFEE
    //   STUDY   -> LECTURE, DESIGN, BUS_OUT, COFFEE
    //   DESIGN  -> LECTURE, STUDY, BUS_OUT, COFFEE
    //   DINNER  -> SLEEP, STUDY, GYM, TV
    //   BUS_OUT -> DINNER, GYM
    //   GYM     -> SLEEP, DINNER, TV
    //   TV      -> SLEEP, STUDY
    //   COFFEE  -> BUS_IN, LECTURE, STUDY, DESIGN
    function automatic logic [15:0] successor_mask(input logic [STATE_W-1:0] from_state);
        logic [15:0] mask;
        mask = 16'h0000;
        case (from_state)
            S_SLEEP:   mask = 16'h0002;
            S_AWAKE:   mask = 16'h0404;
            S_BUS_IN:  mask = 16'h0008;
            S_LECTURE: mask = 16'h04B0;
            S_STUDY:   mask = 16'h04A8;
            S_DESIGN:  mask = 16'h0498;
            S_DINNER:  mask = 16'h0311;
            S_BUS_OUT: mask = 16'h0140;
            S_GYM:     mask = 16'h0241;
            S_TV:      mask = 16'h0011;
            S_COFFEE:  mask = 16'h003C;
            default:   mask = 16'h0000;
        endcase
        return mask;
    endfunction

    // A move is legal only between defined codes and when listed in the table.
    function automatic logic is_legal_move(input logic [STATE_W-1:0] from_state,
                                           input logic [STATE_W-1:0] to_state);
        logic [15:0] mask;
        logic        codes_ok;
        mask     = successor_mask(from_state);
        codes_ok = (from_state < STATE_W'(NUM_STATES)) && (to_state < STATE_W'(NUM_STATES));
        return codes_ok && mask[to_state[3:0]];
    endfunction

endpackage

// File: rtl/student_log_fifo.sv
// Synchronous first-word-fall-through FIFO for transition records.
// The head entry is visible the cycle after it is written; when empty the
// head data reads as zero. A push into a full FIFO is accepted only if a pop
// happens on the same edge, otherwise it is dropped and reported on drop.
module student_log_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output logic             drop
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic full;
    logic do_pop;
    logic do_push;

    assign valid   = (count_reg != '0);
    assign full    = (count_reg == FULL_COUNT);
    assign do_pop  = pop && valid;
    // The slot freed by a simultaneous pop makes room for the push.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    assign head_data = valid ? mem_reg[rd_ptr_reg] : '0;

    // Storage array; contents need no reset because valid gates the head.
    always_ff @(posedge clk) begin
        if (do_push && !srst) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap freely.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/student_day_logger.sv
// Student day logger: watches the student FSM state code, records every
// state change as {from, to, dwell} in a small FIFO, counts days
// (SLEEP->AWAKE), tracks dropped records and, when the macro
// STUDENT_LOG_ILLEGAL_CHECK_EN is defined, flags moves that are not in the
// package successor table.
module student_day_logger
    import student_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DWELL_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         state_out,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [4:0]         rec_from,
    output logic [4:0]         rec_to,
    output logic [DWELL_W-1:0] rec_dwell,
    output logic [7:0]         day_cnt,
    output logic               overflow,
    output logic [7:0]         drop_cnt,
    output logic               err_illegal
);

    localparam int REC_W = 2 * STATE_W + DWELL_W;
    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    logic [4:0]         cur_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic [7:0]         day_cnt_reg;
    logic [7:0]         drop_cnt_reg;
    logic               overflow_reg;

    logic               transition;
    logic               day_start;
    logic               fifo_drop;
    logic [REC_W-1:0]   push_data;
    logic [REC_W-1:0]   head_data;

    // Detection is masked while reset is held so nothing is recorded then.
    assign transition = !rst && (state_out != cur_reg);
    assign day_start  = transition && (cur_reg == S_SLEEP) && (state_out == S_AWAKE);
    assign push_data  = {cur_reg, state_out, dwell_reg};

    student_log_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (clk),
        .srst      (rst),
        .push      (transition),
        .push_data (push_data),
        .pop       (rec_ready),
        .valid     (rec_valid),
        .head_data (head_data),
        .drop      (fifo_drop)
    );

    assign {rec_from, rec_to, rec_dwell} = head_data;
    assign day_cnt  = day_cnt_reg;
    assign drop_cnt = drop_cnt_reg;
    assign overflow = overflow_reg;

    // Track the last sampled state and how many cycles it has been held.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_reg   <= S_SLEEP;
            dwell_reg <= DWELL_ONE;
        end else if (transition) begin
            cur_reg   <= state_out;
            dwell_reg <= DWELL_ONE;
        end else if (dwell_reg != DWELL_MAX) begin
            dwell_reg <= dwell_reg + 1'b1;
        end
    end

    // Day counter wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            day_cnt_reg <= '0;
        end else if (day_start) begin
            day_cnt_reg <= day_cnt_reg + 1'b1;
        end
    end

    // Sticky overflow and saturating count of records the FIFO had no room for.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (fifo_drop) begin
            overflow_reg <= 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_reg <= drop_cnt_reg + 1'b1;
            end
        end
    end

`ifdef STUDENT_LOG_ILLEGAL_CHECK_EN
    logic err_illegal_reg;

    // Sticky flag for moves outside the successor table; the record is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal_reg <= 1'b0;
        end else if (transition && !is_legal_move(cur_reg, state_out)) begin
            err_illegal_reg <= 1'b1;
        end
    end

    assign err_illegal = err_illegal_reg;
`else
    assign err_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_student_day_logger.sv
`timescale 1ns/1ps
module tb_student_day_logger;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int DMAX  = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    state_out;
    logic          rec_valid;
    logic          rec_ready;
    logic [4:0]    rec_from;
    logic [4:0]    rec_to;
    logic [DW-1:0] rec_dwell;
    logic [7:0]    day_cnt;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          err_illegal;

    always #5 clk = ~clk;

    student_day_logger #(
        .FIFO_DEPTH (DEPTH),
        .DWELL_W    (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .state_out   (state_out),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_from    (rec_from),
        .rec_to      (rec_to),
        .rec_dwell   (rec_dwell),
        .day_cnt     (day_cnt),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .err_illegal (err_illegal)
    );

    typedef struct {
        int f_state;
        int t_state;
        int dwell;
    } rec_t;

    // Expected FIFO contents (scoreboard) and expected scalar outputs.
    rec_t exp_q[$];
    int   m_cur   = 0;
    int   m_dwell = 1;
    int   m_day   = 0;
    int   m_drop  = 0;
    bit   m_ovf   = 0;
    bit   m_err   = 0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Day plan written as successor lists.
    function automatic bit tb_legal(input int f, input int t);
        case (f)
            0:  return t inside {1};
            1:  return t inside {2, 10};
            2:  return t inside {3};
            3:  return t inside {4, 5, 7, 10};
            4:  return t inside {3, 5, 7, 10};
            5:  return t inside {3, 4, 7, 10};
            6:  return t inside {0, 4, 8, 9};
            7:  return t inside {6, 8};
            8:  return t inside {0, 6, 9};
            9:  return t inside {0, 4};
            10: return t inside {2, 3, 4, 5};
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: applies the logging rules at every rising edge.
    always @(posedge clk) begin : model
        rec_t r;
        if (rst) begin
            m_cur   = 0;
            m_dwell = 1;
            exp_q.delete();
            m_day   = 0;
            m_drop  = 0;
            m_ovf   = 0;
            m_err   = 0;
        end else if (int'(state_out) != m_cur) begin
            r.f_state = m_cur;
            r.t_state = int'(state_out);
            r.dwell   = m_dwell;
`ifdef STUDENT_LOG_ILLEGAL_CHECK_EN
            if (!tb_legal(m_cur, int'(state_out))) m_err = 1;
`endif
            if (m_cur == 0 && state_out == 5'd1) m_day = (m_day + 1) % 256;
            // Any pop on this edge was already taken out by the monitor.
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(r);
            end else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
            m_cur   = int'(state_out);
            m_dwell = 1;
        end else if (m_dwell < DMAX) begin
            m_dwell++;
        end
    end

    // Monitor: compares the presented head and flags against the scoreboard.
    always @(negedge clk) begin
        check("rec_valid", int'(rec_valid), int'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("rec_from", int'(rec_from), exp_q[0].f_state);
            check("rec_to", int'(rec_to), exp_q[0].t_state);
            check("rec_dwell", int'(rec_dwell), exp_q[0].dwell);
            if (rec_ready && !rst) begin
                $display("rec from=%0d to=%0d dwell=%0d", rec_from, rec_to, rec_dwell);
                void'(exp_q.pop_front());
            end
        end
        check("day_cnt", int'(day_cnt), m_day);
        check("overflow", int'(overflow), int'(m_ovf));
        check("drop_cnt", int'(drop_cnt), m_drop);
        check("err_illegal", int'(err_illegal), int'(m_err));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int exp_err_directed;

    initial begin
        rst       = 1'b1;
        state_out = 5'd0;
        rec_ready = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_rec_valid", int'(rec_valid), 0);
        check("rst_rec_from", int'(rec_from), 0);
        check("rst_rec_to", int'(rec_to), 0);
        check("rst_rec_dwell", int'(rec_dwell), 0);

        // First day start: SLEEP held, then AWAKE.
        @(posedge clk); #1;
        rst       = 1'b0;
        rec_ready = 1'b1;
        tick(4);
        state_out = 5'd1;
        tick(1);
        @(negedge clk);
        check("first_valid", int'(rec_valid), 1);
        check("first_from", int'(rec_from), 0);
        check("first_to", int'(rec_to), 1);
        check("first_dwell", int'(rec_dwell), 5);
        check("first_day", int'(day_cnt), 1);

        // Five transitions with the consumer stalled: one record dropped.
        @(posedge clk); #1;
        rec_ready = 1'b0;
        for (int i = 2; i <= 6; i++) begin
            state_out = 5'(i);
            tick(1);
        end
        @(negedge clk);
        check("stall_overflow", int'(overflow), 1);
        check("stall_drop", int'(drop_cnt), 1);
        @(posedge clk); #1;
        rec_ready = 1'b1;
        tick(5);

        // Fill, then push and pop on the same edge: nothing dropped.
        rec_ready = 1'b0;
        for (int i = 7; i <= 10; i++) begin
            state_out = 5'(i);
            tick(1);
        end
        state_out = 5'd0;
        rec_ready = 1'b1;
        tick(1);
        @(negedge clk);
        check("full_pushpop_drop", int'(drop_cnt), 1);
        check("full_pushpop_valid", int'(rec_valid), 1);
        @(posedge clk); #1;
        tick(5);

        // Long dwell saturates.
        state_out = 5'd3;
        tick(300);
        state_out = 5'd4;
        tick(1);
        @(negedge clk);
        check("sat_dwell", int'(rec_dwell), 255);
        @(posedge clk); #1;
        tick(2);

        // LECTURE->AWAKE and an undefined code.
        state_out = 5'd3;
        tick(2);
        state_out = 5'd1;
        tick(1);
        state_out = 5'd20;
        tick(1);
`ifdef STUDENT_LOG_ILLEGAL_CHECK_EN
        exp_err_directed = 1;
`else
        exp_err_directed = 0;
`endif
        @(negedge clk);
        check("illegal_flag", int'(err_illegal), exp_err_directed);
        @(posedge clk); #1;
        tick(3);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 15) == 0)
                    state_out = 5'($urandom_range(11, 31));
                else
                    state_out = 5'($urandom_range(0, 10));
            end
            rec_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end

        // Reset with pending records.
        rec_ready = 1'b1;
        tick(6);
        rec_ready = 1'b0;
        state_out = 5'd0;
        tick(2);
        for (int i = 1; i <= 3; i++) begin
            state_out = 5'(i);
            tick(1);
        end
        rst = 1'b1;
        tick(1);
        @(negedge clk);
        check("midrst_valid", int'(rec_valid), 0);
        check("midrst_day", int'(day_cnt), 0);
        check("midrst_drop", int'(drop_cnt), 0);
        check("midrst_overflow", int'(overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/student_day_logger.md
STUDENT_DAY_LOGGER -- requirements
Module: student_day_logger

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning transition-record FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter DWELL_W, default 8, meaning dwell counter width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port state_out, input, 5, student FSM state code, sampled every cycle.
REQ-006 SHALL have port rec_valid, output, 1, FIFO head record available.
REQ-007 SHALL have port rec_ready, input, 1, consumer accepts head record.
REQ-008 SHALL have port rec_from, output, 5, head record previous state.
REQ-009 SHALL have port rec_to, output, 5, head record new state.
REQ-010 SHALL have port rec_dwell, output, DWELL_W, head record cycles spent in rec_from.
REQ-011 SHALL have port day_cnt, output, 8, count of SLEEP->AWAKE transitions.
REQ-012 SHALL have port overflow, output, 1, sticky: at least one record dropped.
REQ-013 SHALL have port drop_cnt, output, 8, dropped-record count.
REQ-014 SHALL have port err_illegal, output, 1, sticky illegal-transition flag.

Function
REQ-015 SHALL hold cur_q (last sampled state) and detect a transition at any edge where state_out != cur_q, then load cur_q <= state_out.
REQ-016 SHALL keep dwell_cnt at 1 after reset and after each transition, incrementing by 1 on each non-transition edge and saturating at 2^DWELL_W-1.
REQ-017 SHALL push {cur_q, state_out, dwell_cnt} at the transition edge; rec_valid rises the following cycle (latency 1).
REQ-018 SHALL pop the head on an edge with rec_valid && rec_ready; rec_* SHALL be stable while rec_valid && !rec_ready.
REQ-019 SHALL accept the push when the FIFO is full only if a pop occurs on the same edge; otherwise drop the record, set overflow, and increment drop_cnt (saturating at 255).
REQ-020 SHALL hold FIFO contents on an empty pop attempt; rec_valid stays 0.
REQ-021 SHALL increment day_cnt (wrapping 255->0) on each S_SLEEP->S_AWAKE transition.
REQ-022 SHALL assert rec_valid continuously while the FIFO is non-empty; records leave in arrival order.

Reset
REQ-023 SHALL, on rst: cur_q=S_SLEEP, dwell_cnt=1, FIFO flushed, rec_valid=0, rec_from/rec_to/rec_dwell=0, day_cnt=0, overflow=0, drop_cnt=0, err_illegal=0.
REQ-024 SHALL let reset mid-operation discard all pending records with no partial pop, and suppress detection while rst=1.

Configuration
REQ-025 SHALL implement the legality check only when STUDENT_LOG_ILLEGAL_CHECK_EN is defined: err_illegal sets on a code >10 or on a transition absent from the package successor table; the record is still pushed.
REQ-026 SHALL, without STUDENT_LOG_ILLEGAL_CHECK_EN, tie err_illegal to 0 and contain no table logic.

Structure
REQ-027 SHALL take from shared package student_pkg: the 5-bit state typedef, codes S_SLEEP=0, S_AWAKE=1, S_BUS_IN=2, S_LECTURE=3, S_STUDY=4, S_DESIGN=5, S_DINNER=6, S_BUS_OUT=7, S_GYM=8, S_TV=9, S_COFFEE=10, and the legal-successor table.
REQ-028 SHALL instantiate exactly one sub-module, student_log_fifo (synchronous FIFO, FIFO_DEPTH x (10+DWELL_W)).

Verification
REQ-029 SHALL cover: state_out 0 for 5 cycles after reset, then 1 -> record {0,1,5} with rec_valid 1 cycle later; day_cnt=1.
REQ-030 SHALL cover: rec_ready=0 with 5 transitions at FIFO_DEPTH=4 -> 4 records held, overflow=1, drop_cnt=1, FIFO order preserved.
REQ-031 SHALL cover: full FIFO with push and rec_ready=1 on the same edge -> no drop, count stays 4.
REQ-032 SHALL cover: state 3 held 300 cycles with DWELL_W=8 -> rec_dwell=255.
REQ-033 SHALL cover: with STUDENT_LOG_ILLEGAL_CHECK_EN defined, 3->1 or a code of 20 -> err_illegal=1 next cycle with the record still pushed; without the macro -> err_illegal stays 0.
REQ-034 SHALL cover: rst asserted with 3 pending records -> rec_valid=0 next cycle and all counters 0.
